// File: rtl/cache_pkg.sv
// Shared helpers for the set-associative cache: width math and controller state encoding.
// Pure declarations; no latency or flow control of its own.
package cache_pkg;

   localparam int ADDR_W = 32;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   // A one-way cache still needs a one-bit way field on its ports.
   function automatic int way_width(input int ways);
      return (ways > 1) ? clog2(ways) : 1;
   endfunction

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_LOOKUP,
      ST_MISS_WAIT,
      ST_RESP
   } state_t;

endpackage

// File: rtl/cache_lru_ctrl.sv
// Per-set replacement logic: picks the victim way and computes the post-access age vector.
// Purely combinational, zero latency, no flow control.
module cache_lru_ctrl #(
   parameter int WAYS  = 2,
   parameter int WAY_W = 1
) (
   input  logic [WAYS*WAY_W-1:0] age,
   input  logic [WAYS-1:0]       valid,
   input  logic [WAY_W-1:0]      acc_way,
   output logic [WAY_W-1:0]      victim,
   output logic [WAYS*WAY_W-1:0] next_age
);

   logic             found;
   logic [WAY_W-1:0] old_age;
   logic [WAY_W-1:0] cur;

   // An empty way always wins over evicting the oldest resident line.
   always_comb begin
      victim = '0;
      found  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!valid[w] && !found) begin
            victim = WAY_W'(w);
            found  = 1'b1;
         end
      end
      if (!found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age[w*WAY_W +: WAY_W] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
         end
      end
   end

   always_comb begin
      old_age  = age[int'(acc_way)*WAY_W +: WAY_W];
      next_age = age;
      cur      = '0;
      for (int w = 0; w < WAYS; w++) begin
         cur = age[w*WAY_W +: WAY_W];
         if (WAY_W'(w) == acc_way) next_age[w*WAY_W +: WAY_W] = '0;
         else if (cur < old_age)   next_age[w*WAY_W +: WAY_W] = cur + 1'b1;
      end
   end

endmodule

// File: rtl/cache_sa_lookup_fill.sv
// N-way set-associative lookup/fill controller with LRU replacement and saturating stats.
// Hit responds 2 cycles after accept, miss 1 cycle after fill; one request in flight, req_ready low while busy.
module cache_sa_lookup_fill
   import cache_pkg::*;
#(
   parameter int WAYS            = 2,
   parameter int BLOCK_SIZE_BYTE = 16,
   parameter int CACHE_SIZE_BYTE = 32768,
   parameter int CNT_W           = 16,
   localparam int OFFSET_W = clog2(BLOCK_SIZE_BYTE),
   localparam int SETS     = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAYS),
   localparam int INDEX_W  = clog2(SETS),
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
   localparam int WAY_W    = way_width(WAYS),
   localparam int LINE_W   = BLOCK_SIZE_BYTE * 8
) (
   input  logic              clk2,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              fill_req,
   input  logic              fill_valid,
   input  logic [LINE_W-1:0] fill_data,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic [WAY_W-1:0]  resp_way,
   output logic [LINE_W-1:0] resp_data,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   state_t             state;
   logic [INDEX_W-1:0] sweep;
   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag;
   logic [WAY_W-1:0]   vict;

   logic               valid_mem [SETS][WAYS];
   logic [TAG_W-1:0]   tag_mem   [SETS][WAYS];
   logic [LINE_W-1:0]  data_mem  [SETS][WAYS];
   logic [WAY_W-1:0]   age_mem   [SETS][WAYS];

   logic [WAYS-1:0]       set_valid;
   logic [WAYS*WAY_W-1:0] set_age;
   logic [WAYS*WAY_W-1:0] lru_age;
   logic                  hit;
   logic [WAY_W-1:0]      hit_way;
   logic [WAY_W-1:0]      acc_way;
   logic [WAY_W-1:0]      lru_victim;

   logic unused_offset;
   assign unused_offset = ^req_addr[OFFSET_W-1:0];

   always_comb begin
      set_valid = '0;
      set_age   = '0;
      hit       = 1'b0;
      hit_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         set_valid[w]               = valid_mem[idx][w];
         set_age[w*WAY_W +: WAY_W]  = age_mem[idx][w];
         if (valid_mem[idx][w] && (tag_mem[idx][w] == tag) && !hit) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Ages are updated for the hit way in LOOKUP and for the stored victim on fill.
   assign acc_way = (state == ST_LOOKUP) ? hit_way : vict;

   cache_lru_ctrl #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_lru (
      .age      (set_age),
      .valid    (set_valid),
      .acc_way  (acc_way),
      .victim   (lru_victim),
      .next_age (lru_age)
   );

   always_ff @(posedge clk2) begin
      if (reset) begin
         state      <= ST_INIT;
         sweep      <= '0;
         idx        <= '0;
         tag        <= '0;
         vict       <= '0;
         req_ready  <= 1'b0;
         fill_req   <= 1'b0;
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
         resp_way   <= '0;
         resp_data  <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_INIT: begin
               for (int w = 0; w < WAYS; w++) begin
                  valid_mem[sweep][w] <= 1'b0;
                  age_mem[sweep][w]   <= WAY_W'(w);
               end
               sweep <= sweep + 1'b1;
               if (sweep == INDEX_W'(SETS - 1)) begin
                  state     <= ST_IDLE;
                  req_ready <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (req_valid) begin
                  tag       <= req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
                  idx       <= req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
                  req_ready <= 1'b0;
                  state     <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (hit) begin
                  for (int w = 0; w < WAYS; w++) age_mem[idx][w] <= lru_age[w*WAY_W +: WAY_W];
                  resp_valid <= 1'b1;
                  resp_hit   <= 1'b1;
                  resp_way   <= hit_way;
                  resp_data  <= data_mem[idx][hit_way];
                  hit_count  <= (hit_count == '1) ? hit_count : hit_count + 1'b1;
                  state      <= ST_RESP;
               end else begin
                  vict       <= lru_victim;
                  miss_count <= (miss_count == '1) ? miss_count : miss_count + 1'b1;
                  fill_req   <= 1'b1;
                  state      <= ST_MISS_WAIT;
               end
            end
            ST_MISS_WAIT: begin
               if (fill_valid) begin
                  valid_mem[idx][vict] <= 1'b1;
                  tag_mem[idx][vict]   <= tag;
                  data_mem[idx][vict]  <= fill_data;
                  for (int w = 0; w < WAYS; w++) age_mem[idx][w] <= lru_age[w*WAY_W +: WAY_W];
                  fill_req   <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_hit   <= 1'b0;
                  resp_way   <= vict;
                  resp_data  <= fill_data;
                  state      <= ST_RESP;
               end
            end
            ST_RESP: begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_sa_lookup_fill.sv
// Scoreboard bench: reference model keeps per-set lines and a recency list; monitor checks every response.
module tb_cache_sa_lookup_fill;

   localparam int WAYS    = 2;
   localparam int BSB     = 16;
   localparam int CSB     = 32768;
   localparam int CNT_W   = 4;
   localparam int SETS    = CSB / (BSB * WAYS);
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic         clk2 = 1'b0;
   logic         reset = 1'b1;
   logic         req_valid = 1'b0;
   logic [31:0]  req_addr = '0;
   logic         fill_valid = 1'b0;
   logic [127:0] fill_data = '0;
   logic         req_ready, fill_req, resp_valid, resp_hit;
   logic [0:0]   resp_way;
   logic [127:0] resp_data;
   logic [CNT_W-1:0] hit_count, miss_count;

   cache_sa_lookup_fill #(
      .WAYS(WAYS), .BLOCK_SIZE_BYTE(BSB), .CACHE_SIZE_BYTE(CSB), .CNT_W(CNT_W)
   ) dut (
      .clk2(clk2), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .fill_req(fill_req), .fill_valid(fill_valid), .fill_data(fill_data),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way), .resp_data(resp_data),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk2 = ~clk2;

   int cyc = 0;
   always @(posedge clk2) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: lines per set, plus a recency list per set (position 0 = most recent).
   bit           m_valid [SETS][WAYS];
   logic [27:0]  m_line  [SETS][WAYS];
   logic [127:0] m_data  [SETS][WAYS];
   int           m_order [SETS][WAYS];
   int           m_hits, m_misses;

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_order[s][w] = w;
         end
      m_hits   = 0;
      m_misses = 0;
   endfunction

   function automatic void touch(input int s, input int w);
      int p;
      p = 0;
      for (int q = 0; q < WAYS; q++) if (m_order[s][q] == w) p = q;
      for (int q = p; q > 0; q--) m_order[s][q] = m_order[s][q-1];
      m_order[s][0] = w;
   endfunction

   typedef struct {
      bit           hit;
      int           way;
      logic [127:0] data;
      int           edge_at;
      int           hc;
      int           mc;
   } exp_t;

   exp_t         sb[$];
   int           fill_edge = 0;
   logic [127:0] pending_fill = '0;
   bit           auto_fill = 1'b1;
   int           last_way = -1;
   bit           last_hit = 1'b0;
   logic [127:0] last_data = '0;

   task automatic issue(input logic [31:0] addr, input logic [127:0] fdata);
      int   s, n, w;
      logic [27:0] line;
      exp_t e;
      s    = int'((addr >> 4) & (SETS - 1));
      line = addr[31:4];
      n    = 0;
      @(negedge clk2);
      while (!req_ready && n < 3000) begin
         @(negedge clk2);
         n++;
      end
      if (!req_ready) begin
         tests++;
         fails++;
         $display("FAIL issue_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
         return;
      end
      w = -1;
      for (int q = 0; q < WAYS; q++) if (m_valid[s][q] && m_line[s][q] == line) w = q;
      if (w >= 0) begin
         e.hit     = 1'b1;
         e.data    = m_data[s][w];
         e.edge_at = cyc + 2;
         if (m_hits < CNT_MAX) m_hits++;
      end else begin
         for (int q = WAYS - 1; q >= 0; q--) if (!m_valid[s][q]) w = q;
         if (w < 0) w = m_order[s][WAYS-1];
         m_valid[s][w] = 1'b1;
         m_line[s][w]  = line;
         m_data[s][w]  = fdata;
         pending_fill  = fdata;
         e.hit         = 1'b0;
         e.data        = fdata;
         e.edge_at     = -1;
         if (m_misses < CNT_MAX) m_misses++;
      end
      touch(s, w);
      e.way = w;
      e.hc  = m_hits;
      e.mc  = m_misses;
      sb.push_back(e);
      req_valid = 1'b1;
      req_addr  = addr;
      @(negedge clk2);
      req_valid = 1'b0;
      req_addr  = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk2);
         n++;
      end
      @(negedge clk2);
      check("drain_empty", sb.size(), 0);
   endtask

   // Releases reset and counts cycles until req_ready; optionally pulses fill_valid during the sweep.
   task automatic measure_sweep(input int pulse_at);
      int n;
      n = 0;
      reset = 1'b0;
      while (!req_ready && n < 1100) begin
         @(posedge clk2);
         #1;
         n++;
         if (n == pulse_at) begin
            fill_valid = 1'b1;
            fill_data  = {4{$urandom}};
         end else if (n == pulse_at + 1) begin
            fill_valid = 1'b0;
         end
      end
      fill_valid = 1'b0;
      check("init_sweep_cycles", n, 1024);
      check("hit_count_after_init", hit_count, 0);
      check("miss_count_after_init", miss_count, 0);
   endtask

   // Fill responder: supplies the line the driver chose, after a random delay.
   initial begin
      forever begin
         @(negedge clk2);
         if (auto_fill && fill_req && !fill_valid) begin
            repeat ($urandom_range(0, 3)) @(negedge clk2);
            fill_data  = pending_fill;
            fill_valid = 1'b1;
            fill_edge  = cyc + 1;
            @(negedge clk2);
            fill_valid = 1'b0;
            fill_data  = {4{$urandom}};
         end
      end
   end

   // Monitor: every response pulse is matched against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk2);
         if (resp_valid) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding, way %0d", resp_way);
            end else begin
               e = sb.pop_front();
               check("resp_hit", resp_hit, e.hit);
               check("resp_way", resp_way, e.way);
               check("resp_data", resp_data, e.data);
               check("resp_cycle", cyc, e.hit ? e.edge_at : fill_edge);
               check("hit_count", hit_count, e.hc);
               check("miss_count", miss_count, e.mc);
               last_way  = int'(resp_way);
               last_hit  = resp_hit;
               last_data = resp_data;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   logic [127:0] pat_a5, pat_b, pat_c, pat_b2;
   logic [17:0]  tag_pool [4];

   initial begin
      model_reset();
      pat_a5 = {16{8'hA5}};
      pat_b  = {4{$urandom}};
      pat_c  = {4{$urandom}};
      pat_b2 = {4{$urandom}};
      for (int i = 0; i < 4; i++) tag_pool[i] = 18'($urandom);

      repeat (3) @(negedge clk2);
      check("ready_in_reset", req_ready, 0);
      check("fill_req_in_reset", fill_req, 0);
      check("resp_valid_in_reset", resp_valid, 0);
      check("resp_data_in_reset", resp_data, 0);
      measure_sweep(-5);

      // Single line: miss then hit.
      issue(32'h0000_1230, pat_a5);
      drain();
      check("A_first_miss", last_hit, 0);
      check("A_fill_way", last_way, 0);
      check("A_miss_count", miss_count, 1);
      issue(32'h0000_1230, '0);
      drain();
      check("A_rehit", last_hit, 1);
      check("A_rehit_data", last_data, pat_a5);
      check("A_hit_count", hit_count, 1);

      // Second line in the same set lands in the other way; then force B to be LRU.
      issue(32'h0000_5230, pat_b);
      drain();
      check("B_fill_way", last_way, 1);
      issue(32'h0000_1234, '0);
      issue(32'h0000_523C, '0);
      issue(32'h0000_1230, '0);
      drain();
      check("A_mru_hit_way", last_way, 0);
      issue(32'h0000_9230, pat_c);
      drain();
      check("C_evicts_way1", last_way, 1);
      issue(32'h0000_5230, pat_b2);
      drain();
      check("B_evicts_way0", last_way, 0);
      check("B_refill_miss", last_hit, 0);

      // Hit counter saturation.
      for (int i = 0; i < 20; i++) issue(32'h0000_9230, '0);
      drain();
      check("hit_count_saturates", hit_count, CNT_MAX);

      // Stray fill in IDLE changes nothing.
      @(negedge clk2);
      fill_valid = 1'b1;
      fill_data  = {4{$urandom}};
      @(negedge clk2);
      fill_valid = 1'b0;
      repeat (2) @(negedge clk2);
      check("idle_fill_ready", req_ready, 1);
      check("idle_fill_no_req", fill_req, 0);
      issue(32'h0000_9230, '0);
      drain();
      check("idle_fill_no_write", last_data, pat_c);

      // Randomised traffic over a few hot sets with a small tag pool to force evictions.
      for (int i = 0; i < 250; i++) begin
         logic [31:0] a;
         logic [9:0]  ix;
         case ($urandom_range(0, 3))
            0: ix = 10'h123;
            1: ix = 10'h000;
            2: ix = 10'h3FF;
            default: ix = 10'($urandom);
         endcase
         a = {tag_pool[$urandom_range(0, 3)], ix, 4'($urandom)};
         issue(a, {4{$urandom}});
         repeat ($urandom_range(0, 2)) @(negedge clk2);
      end
      drain();

      // Reset while a miss is outstanding; the late fill must be dropped.
      auto_fill = 1'b0;
      @(negedge clk2);
      while (!req_ready) @(negedge clk2);
      req_valid = 1'b1;
      req_addr  = 32'hABC0_0120;
      @(negedge clk2);
      req_valid = 1'b0;
      repeat (3) @(negedge clk2);
      check("abort_fill_req", fill_req, 1);
      reset = 1'b1;
      @(negedge clk2);
      check("abort_ready_low", req_ready, 0);
      check("abort_fill_req_low", fill_req, 0);
      measure_sweep(2);
      model_reset();
      auto_fill = 1'b1;
      issue(32'h0000_1230, pat_b);
      drain();
      check("post_reset_miss", last_hit, 0);
      check("post_reset_miss_count", miss_count, 1);

      repeat (5) @(negedge clk2);
      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cache_sa_lookup_fill.md
Name: cache_sa_lookup_fill

Overview:
- Parametrised N-way set-associative cache controller: one lookup per request, hit or miss, miss fill, LRU replacement.
- Successor of the direct-mapped lookup/update block; adds associativity, valid/ready handshake, a per-set LRU, a power-on valid sweep and saturating statistics.
- Sits between the address trace generator and the next-level memory model in each simulated core.

Parameters:
- WAYS, 2: associativity; power of two, 1..8.
- BLOCK_SIZE_BYTE, 16: line size in bytes; power of two.
- CACHE_SIZE_BYTE, 32768: total data capacity.
- CNT_W, 16: width of the hit and miss counters.
- Derived: OFFSET_W=clog2(BLOCK_SIZE_BYTE), SETS=CACHE_SIZE_BYTE/(BLOCK_SIZE_BYTE*WAYS), INDEX_W=clog2(SETS), TAG_W=32-INDEX_W-OFFSET_W, WAY_W=max(1,clog2(WAYS)).

Ports:
- clk2  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  lookup request present.
- req_ready  out  1  controller can accept a request.
- req_addr  in  32  byte address: tag=[31:INDEX_W+OFFSET_W], index=[INDEX_W+OFFSET_W-1:OFFSET_W].
- fill_req  out  1  miss outstanding; line must be supplied.
- fill_valid  in  1  fill_data valid this cycle.
- fill_data  in  BLOCK_SIZE_BYTE*8  line from next level.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  1 = hit, 0 = miss that was filled.
- resp_way  out  WAY_W  way hit or way filled.
- resp_data  out  BLOCK_SIZE_BYTE*8  line returned.
- hit_count  out  CNT_W  saturating hit count.
- miss_count  out  CNT_W  saturating miss count.

Behaviour:
- Storage per set: for each way, a valid bit, tag and data; a WAY_W-bit age per way.
- States: INIT, IDLE, LOOKUP, MISS_WAIT, RESP.
- reset (any state, including mid-miss): go to INIT with sweep index 0; drop any pending request; clear both counters; req_ready=0, fill_req=0, resp_valid=0, resp_hit=0, resp_way=0, resp_data=0.
- INIT: one set per cycle, clear all valid bits and set age[w]=w. After SETS cycles go to IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch tag and index, go to LOOKUP. req_ready is 0 in every other state.
- LOOKUP (1 cycle): compare all ways with valid&&tag match.
  - Hit: go to RESP with the hit way; hit_count+1.
  - Miss: victim = lowest-index invalid way; if none, the way whose age is WAYS-1. miss_count+1. Go to MISS_WAIT.
- MISS_WAIT: fill_req=1, held until fill_valid. On fill_valid, write {valid=1, tag, fill_data} into the victim way; go to RESP.
- fill_valid in any state other than MISS_WAIT is ignored.
- RESP (1 cycle): resp_valid=1 with hit/way/data, then IDLE. resp_* hold their values until the next RESP.
- LRU update, on every hit and on every fill: accessed way age becomes 0; every way whose age was below the old age of the accessed way gets +1. Ages in a set always form a permutation of 0..WAYS-1.
- Latency from accept: hit = resp_valid 2 cycles later. Miss = resp_valid 1 cycle after the fill_valid cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.
- WAYS=1 degenerates to direct-mapped: victim is always way 0 and resp_way=0.

Decomposition:
- Package cache_pkg: clog2 function, derived-width constants, FSM state encoding.
- Sub-module cache_lru_ctrl (combinational): inputs are the set's age vector, valid vector and accessed way. Outputs are the victim way and the next age vector.

Test Plan (WAYS=2, 16 B lines, 32 KB: SETS=1024, INDEX_W=10, TAG_W=18):
- Reset, then idle -> req_ready=0 for exactly 1024 cycles, then 1; hit_count=miss_count=0.
- Request 0x0000_1230; fill_data=0xA5 pattern -> fill_req=1, resp_hit=0, resp_way=0, miss_count=1. Repeat the request -> resp_hit=1, resp_data=0xA5 pattern, resp 2 cycles after accept, hit_count=1.
- 0x0000_1230 then 0x0000_5230 (same set 0x123) -> way0, then way1. Both re-requests hit with their own data.
- Sequence A=0x1230 fill, B=0x5230 fill, A hit, C=0x9230 miss -> C evicts way1 (B). Then B misses and evicts way0 (A).
- Reset asserted during MISS_WAIT, fill_valid pulsed 3 cycles later -> no resp_valid, no array write, counters 0, 1024-cycle INIT sweep repeats.
- CNT_W=4, 20 hits to one address -> hit_count holds 15. fill_valid pulsed while in IDLE -> no state change.
